// File: rtl/uart_time_rx.sv
// uart_time_rx
// Receives "HH:MM" plus a CR or LF terminator over an 8N1 UART line. It
// presents the accepted time as a parallel hours/minutes value, together with
// a one-cycle load strobe, to the time-of-day counter's UART load path.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   rx           UART serial input (idle high, asynchronous to clock)
//   timp_ore     last accepted hours value, 0..23
//   timp_minute  last accepted minutes value, 0..59
//   load         one-cycle pulse; timp_ore/timp_minute are valid while high
//   frame_err    one-cycle pulse when a received byte has a low stop bit
//   parse_err    one-cycle pulse when a byte or value breaks the command format
module uart_time_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [4:0] timp_ore,
   output logic [5:0] timp_minute,
   output logic       load,
   output logic       frame_err,
   output logic       parse_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [2:0] {
      P_H1,
      P_H2,
      P_COLON,
      P_M1,
      P_M2,
      P_END
   } p_state_t;

   logic             sync1_q, sync1_d;
   logic             rxs_q, rxs_d;
   logic             rxs_prev_q, rxs_prev_d;

   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;

   p_state_t         p_state_q, p_state_d;
   logic [3:0]       h1_q, h1_d, h2_q, h2_d, m1_q, m1_d, m2_q, m2_d;
   logic [4:0]       ore_q, ore_d;
   logic [5:0]       min_q, min_d;
   logic             load_q, load_d;
   logic             parse_err_q, parse_err_d;

   logic             fall_edge;
   logic             sample_tick;
   logic             is_digit;
   logic             is_term;
   logic [3:0]       digit;
   logic [6:0]       hours_full;
   logic [6:0]       minutes_full;
   logic             time_in_range;

   // Two-flop synchronizer on rx. One more delayed copy is kept so that a
   // 1->0 transition can be seen as a start-bit edge.
   always_comb begin
      sync1_d    = rx;
      rxs_d      = sync1_q;
      rxs_prev_d = rxs_q;
   end

   assign fall_edge   = rxs_prev_q & ~rxs_q;
   // The start bit is checked at its midpoint. Every later bit is checked a
   // full bit period after the previous sample.
   assign sample_tick = (rx_state_q == RX_START) ? (clk_cnt_q == HALF_M1)
                                                 : (clk_cnt_q == BIT_M1);

   // Receiver next state. The bit timer restarts at every sample point, so
   // samples stay one bit period apart and centred in each bit.
   always_comb begin
      rx_state_d = rx_state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      case (rx_state_q)
         RX_IDLE: begin
            clk_cnt_d = '0;
            if (fall_edge) begin
               rx_state_d = RX_START;
               bit_cnt_d  = '0;
            end
         end
         RX_START: begin
            if (sample_tick) begin
               clk_cnt_d  = '0;
               rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (sample_tick) begin
               clk_cnt_d = '0;
               shift_d   = {rxs_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (sample_tick) begin
               clk_cnt_d  = '0;
               rx_state_d = rxs_q ? RX_IDLE : RX_WAIT_HIGH;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         RX_WAIT_HIGH: begin
            // A held-low line (break) must not look like a stream of frames.
            if (rxs_q) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Receiver outputs. The stop-bit sample decides whether the byte is
   // delivered or reported as a framing error.
   always_comb begin
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (rx_state_q == RX_STOP && sample_tick) begin
         byte_valid_d = rxs_q;
         frame_err_d  = ~rxs_q;
      end
   end

   // In ASCII '0'..'9' the low nibble is already the digit value (byte - 0x30).
   assign is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);
   assign digit    = shift_q[3:0];
   assign is_term  = (shift_q == 8'h0D) || (shift_q == 8'h0A);

   // Build tens*10 + units as (d<<3)+(d<<1). The largest value is 99, so 7 bits
   // are enough.
   assign hours_full    = ({3'b000, h1_q} << 3) + ({3'b000, h1_q} << 1) + {3'b000, h2_q};
   assign minutes_full  = ({3'b000, m1_q} << 3) + ({3'b000, m1_q} << 1) + {3'b000, m2_q};
   assign time_in_range = (hours_full <= 7'd23) && (minutes_full <= 7'd59);

   // Parser next state. A bad byte drops the partial command. A framing error
   // also drops it, because that byte is lost.
   always_comb begin
      p_state_d = p_state_q;
      h1_d      = h1_q;
      h2_d      = h2_q;
      m1_d      = m1_q;
      m2_d      = m2_q;
      if (frame_err_q) begin
         p_state_d = P_H1;
      end else if (byte_valid_q) begin
         p_state_d = P_H1;
         case (p_state_q)
            P_H1: if (is_digit) begin
               h1_d      = digit;
               p_state_d = P_H2;
            end
            P_H2: if (is_digit) begin
               h2_d      = digit;
               p_state_d = P_COLON;
            end
            P_COLON: if (shift_q == 8'h3A) begin
               p_state_d = P_M1;
            end
            P_M1: if (is_digit) begin
               m1_d      = digit;
               p_state_d = P_M2;
            end
            P_M2: if (is_digit) begin
               m2_d      = digit;
               p_state_d = P_END;
            end
            default: p_state_d = P_H1;
         endcase
      end
   end

   // Parser outputs. Each delivered byte ends in at most one of load or
   // parse_err. The time registers change only together with load.
   always_comb begin
      load_d      = 1'b0;
      parse_err_d = 1'b0;
      ore_d       = ore_q;
      min_d       = min_q;
      if (byte_valid_q) begin
         case (p_state_q)
            P_H1, P_H2, P_M1, P_M2: parse_err_d = ~is_digit;
            P_COLON:                parse_err_d = (shift_q != 8'h3A);
            P_END: begin
               if (is_term && time_in_range) begin
                  load_d = 1'b1;
                  ore_d  = hours_full[4:0];
                  min_d  = minutes_full[5:0];
               end else begin
                  parse_err_d = 1'b1;
               end
            end
            default: parse_err_d = 1'b1;
         endcase
      end
   end

   // State register for synchronizer, receiver and parser. The rx copies reset
   // to the idle-high level so that leaving reset is not seen as a start edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         rxs_q        <= 1'b1;
         rxs_prev_q   <= 1'b1;
         rx_state_q   <= RX_IDLE;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         p_state_q    <= P_H1;
         h1_q         <= '0;
         h2_q         <= '0;
         m1_q         <= '0;
         m2_q         <= '0;
         ore_q        <= '0;
         min_q        <= '0;
         load_q       <= 1'b0;
         parse_err_q  <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         rxs_q        <= rxs_d;
         rxs_prev_q   <= rxs_prev_d;
         rx_state_q   <= rx_state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         p_state_q    <= p_state_d;
         h1_q         <= h1_d;
         h2_q         <= h2_d;
         m1_q         <= m1_d;
         m2_q         <= m2_d;
         ore_q        <= ore_d;
         min_q        <= min_d;
         load_q       <= load_d;
         parse_err_q  <= parse_err_d;
      end
   end

   assign timp_ore    = ore_q;
   assign timp_minute = min_q;
   assign load        = load_q;
   assign frame_err   = frame_err_q;
   assign parse_err   = parse_err_q;

endmodule

// File: tb/tb_uart_time_rx.sv
// tb_uart_time_rx
// Testbench for uart_time_rx with CLKS_PER_BIT = 8. Bytes are sent as serial
// frames with no gap between them. A command-level reference model tracks the
// expected number of loads, parse errors and frame errors, and the last
// accepted time. A monitor counts the pulses the DUT actually produces.
module tb_uart_time_rx;

   localparam int CPB = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx;
   logic [4:0] timp_ore;
   logic [5:0] timp_minute;
   logic       load;
   logic       frame_err;
   logic       parse_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int load_cnt = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int overlap_cnt = 0;
   int last_load_cyc = 0;
   int frame_start = 0;
   int load_start = 0;

   int m_pos = 0;
   int m_dg[4];
   int m_ore = 0;
   int m_min = 0;
   int exp_load = 0;
   int exp_perr = 0;
   int exp_ferr = 0;

   uart_time_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clock(clock),
      .reset(reset),
      .rx(rx),
      .timp_ore(timp_ore),
      .timp_minute(timp_minute),
      .load(load),
      .frame_err(frame_err),
      .parse_err(parse_err)
   );

   // Free-running clock with a cycle counter for latency measurements.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Pulse monitor. It samples on the falling edge, away from the DUT's
   // active edge.
   always @(negedge clock) begin
      if (load === 1'b1) begin
         load_cnt++;
         last_load_cyc = cyc;
      end
      if (parse_err === 1'b1) perr_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
      if ((int'(load) + int'(parse_err) + int'(frame_err)) > 1) overlap_cnt++;
   end

   // Reference model of the command format, indexed by position within
   // "HH:MM<term>".
   task automatic model_byte(input logic [7:0] b, output bit loaded);
      bit ok;
      int hrs;
      int mins;
      loaded = 1'b0;
      if (m_pos == 2)      ok = (b == 8'h3A);
      else if (m_pos == 5) ok = (b == 8'h0D) || (b == 8'h0A);
      else                 ok = (b >= 8'h30) && (b <= 8'h39);
      if (!ok) begin
         exp_perr++;
         m_pos = 0;
      end else if (m_pos == 5) begin
         hrs  = m_dg[0] * 10 + m_dg[1];
         mins = m_dg[2] * 10 + m_dg[3];
         m_pos = 0;
         if (hrs < 24 && mins < 60) begin
            m_ore = hrs;
            m_min = mins;
            exp_load++;
            loaded = 1'b1;
         end else begin
            exp_perr++;
         end
      end else begin
         if (m_pos != 2) m_dg[(m_pos < 2) ? m_pos : m_pos - 1] = int'(b) - 48;
         m_pos++;
      end
   endtask

   // Drives one 8N1 frame. It is entered and left on a falling clock edge, so
   // consecutive calls produce frames with no idle gap.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      frame_start = cyc;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_and_model(input logic [7:0] b);
      bit ld;
      send_byte(b, 1'b1);
      model_byte(b, ld);
      if (ld) load_start = frame_start;
   endtask

   task automatic send_cmd(input string s);
      for (int i = 0; i < s.len(); i++) send_and_model(s[i]);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (timp_ore !== 5'd0) begin errors++; $display("[TB] FAIL reset_ore: got %0d expected 0", timp_ore); end
      checks++; if (timp_minute !== 6'd0) begin errors++; $display("[TB] FAIL reset_min: got %0d expected 0", timp_minute); end
      checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: got %b expected 0", load); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (parse_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parse_err: got %b expected 0", parse_err); end
      reset = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_valid_commands;
      string cmds[3];
      int lat;
      cmds = '{"12:34\015", "23:59\n", "00:00\015"};
      foreach (cmds[k]) begin
         send_cmd(cmds[k]);
         repeat (3 * CPB) @(negedge clock);
         lat = last_load_cyc - load_start;
         checks++; if (load_cnt !== exp_load) begin errors++; $display("[TB] FAIL valid_load_count[%0d]: got %0d expected %0d", k, load_cnt, exp_load); end
         checks++; if (perr_cnt !== exp_perr) begin errors++; $display("[TB] FAIL valid_parse_err_count[%0d]: got %0d expected %0d", k, perr_cnt, exp_perr); end
         checks++; if (timp_ore !== 5'(m_ore)) begin errors++; $display("[TB] FAIL valid_ore[%0d]: got %0d expected %0d", k, timp_ore, m_ore); end
         checks++; if (timp_minute !== 6'(m_min)) begin errors++; $display("[TB] FAIL valid_min[%0d]: got %0d expected %0d", k, timp_minute, m_min); end
         checks++; if (lat < 78 || lat > 82) begin errors++; $display("[TB] FAIL valid_load_latency[%0d]: got %0d expected 78..82 cycles", k, lat); end
      end
   endtask

   task automatic test_range_errors;
      string cmds[3];
      cmds = '{"12:34\015", "24:00\015", "12:60\015"};
      foreach (cmds[k]) begin
         send_cmd(cmds[k]);
         repeat (3 * CPB) @(negedge clock);
         checks++; if (load_cnt !== exp_load) begin errors++; $display("[TB] FAIL range_load_count[%0d]: got %0d expected %0d", k, load_cnt, exp_load); end
         checks++; if (perr_cnt !== exp_perr) begin errors++; $display("[TB] FAIL range_parse_err_count[%0d]: got %0d expected %0d", k, perr_cnt, exp_perr); end
         checks++; if (timp_ore !== 5'(m_ore) || timp_minute !== 6'(m_min)) begin errors++; $display("[TB] FAIL range_hold[%0d]: got %0d:%0d expected %0d:%0d", k, timp_ore, timp_minute, m_ore, m_min); end
      end
   endtask

   task automatic test_format_errors;
      int perr_before;
      perr_before = perr_cnt;
      send_cmd("1a:00\015");
      repeat (3 * CPB) @(negedge clock);
      checks++; if (perr_cnt - perr_before !== 3) begin errors++; $display("[TB] FAIL format_bad_bytes: got %0d parse errors expected 3", perr_cnt - perr_before); end
      checks++; if (perr_cnt !== exp_perr) begin errors++; $display("[TB] FAIL format_model_parse_err: got %0d expected %0d", perr_cnt, exp_perr); end
      send_cmd("07:05\015");
      repeat (3 * CPB) @(negedge clock);
      checks++; if (load_cnt !== exp_load) begin errors++; $display("[TB] FAIL format_recover_load: got %0d expected %0d", load_cnt, exp_load); end
      checks++; if (timp_ore !== 5'd7 || timp_minute !== 6'd5) begin errors++; $display("[TB] FAIL format_recover_time: got %0d:%0d expected 7:5", timp_ore, timp_minute); end
   endtask

   task automatic test_frame_error;
      send_byte(8'h31, 1'b0);
      exp_ferr++;
      m_pos = 0;
      repeat (3 * CPB) @(negedge clock);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clock);
      checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("[TB] FAIL frame_err_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
      checks++; if (load_cnt !== exp_load || perr_cnt !== exp_perr) begin errors++; $display("[TB] FAIL frame_err_side_effects: got load %0d perr %0d expected %0d %0d", load_cnt, perr_cnt, exp_load, exp_perr); end
      send_cmd("09:15\015");
      repeat (3 * CPB) @(negedge clock);
      checks++; if (load_cnt !== exp_load) begin errors++; $display("[TB] FAIL frame_recover_load: got %0d expected %0d", load_cnt, exp_load); end
      checks++; if (timp_ore !== 5'd9 || timp_minute !== 6'd15) begin errors++; $display("[TB] FAIL frame_recover_time: got %0d:%0d expected 9:15", timp_ore, timp_minute); end
   endtask

   task automatic test_glitch_and_reset;
      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clock);
      checks++; if (load_cnt !== exp_load || perr_cnt !== exp_perr || ferr_cnt !== exp_ferr) begin errors++; $display("[TB] FAIL glitch_activity: got %0d/%0d/%0d expected %0d/%0d/%0d", load_cnt, perr_cnt, ferr_cnt, exp_load, exp_perr, exp_ferr); end
      send_cmd("11:");
      // Partial frame for '1' (0x31): start bit, bit0 = 1, then reset mid bit1.
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clock);
      reset = 1'b1;
      #1;
      checks++; if (timp_ore !== 5'd0 || timp_minute !== 6'd0) begin errors++; $display("[TB] FAIL async_reset_time: got %0d:%0d expected 0:0", timp_ore, timp_minute); end
      checks++; if (load !== 1'b0 || parse_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_pulses: got %b%b%b expected 000", load, parse_err, frame_err); end
      @(negedge clock);
      rx = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      m_pos = 0;
      m_ore = 0;
      m_min = 0;
      repeat (2 * CPB) @(negedge clock);
      send_cmd("05:30\015");
      repeat (3 * CPB) @(negedge clock);
      checks++; if (load_cnt !== exp_load || perr_cnt !== exp_perr) begin errors++; $display("[TB] FAIL reset_recover_counts: got load %0d perr %0d expected %0d %0d", load_cnt, perr_cnt, exp_load, exp_perr); end
      checks++; if (timp_ore !== 5'd5 || timp_minute !== 6'd30) begin errors++; $display("[TB] FAIL reset_recover_time: got %0d:%0d expected 5:30", timp_ore, timp_minute); end
   endtask

   task automatic test_random;
      logic [7:0] c[6];
      int h;
      int mn;
      int prev_loads;
      int lat;
      for (int k = 0; k < 10; k++) begin
         h  = int'($urandom_range(0, 29));
         mn = int'($urandom_range(0, 69));
         c[0] = 8'(48 + h / 10);
         c[1] = 8'(48 + h % 10);
         c[2] = 8'h3A;
         c[3] = 8'(48 + mn / 10);
         c[4] = 8'(48 + mn % 10);
         c[5] = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
         if ($urandom_range(0, 3) == 0) c[$urandom_range(0, 5)] = 8'(65 + $urandom_range(0, 20));
         prev_loads = exp_load;
         for (int i = 0; i < 6; i++) send_and_model(c[i]);
         repeat (3 * CPB) @(negedge clock);
         checks++; if (load_cnt !== exp_load || perr_cnt !== exp_perr) begin errors++; $display("[TB] FAIL random_counts[%0d]: got load %0d perr %0d expected %0d %0d", k, load_cnt, perr_cnt, exp_load, exp_perr); end
         checks++; if (timp_ore !== 5'(m_ore) || timp_minute !== 6'(m_min)) begin errors++; $display("[TB] FAIL random_time[%0d]: got %0d:%0d expected %0d:%0d", k, timp_ore, timp_minute, m_ore, m_min); end
         if (exp_load != prev_loads) begin
            lat = last_load_cyc - load_start;
            checks++; if (lat < 78 || lat > 82) begin errors++; $display("[TB] FAIL random_latency[%0d]: got %0d expected 78..82 cycles", k, lat); end
         end
      end
      checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("[TB] FAIL final_frame_err_count: got %0d expected %0d", ferr_cnt, exp_ferr); end
      checks++; if (overlap_cnt !== 0) begin errors++; $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles expected 0", overlap_cnt); end
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      test_reset;
      test_valid_commands;
      test_range_errors;
      test_format_errors;
      test_frame_error;
      test_glitch_and_reset;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
